// File: rtl/bird_spawner.sv
// Single bird slot: picks a random spawn row, flies it left-to-right at a
// frame-paced speed, and handles hits, a respawn delay and escapes off-screen.
module bird_spawner #(
    parameter logic [15:0] SEED          = 16'hACE1,
    parameter int          X_MAX         = 159,
    parameter int          Y_MIN         = 10,
    parameter int          RESPAWN_DELAY = 30
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       enable,
    input  logic [3:0] move_freq,
    input  logic       hit,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic       active,
    output logic       respawn,
    output logic       escaped
);
    // An all-zero Galois LFSR would lock up, so a zero seed is replaced.
    localparam logic [15:0] SEED_EFF   = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0] LFSR_MASK  = 16'hB400;
    localparam int          DW         = (RESPAWN_DELAY < 2) ? 1 : $clog2(RESPAWN_DELAY + 1);
    localparam logic [DW-1:0] DELAY_LOAD = DW'(RESPAWN_DELAY);
    localparam logic [DW-1:0] DELAY_ONE  = DW'(1);
    localparam logic [7:0]  X_LAST     = 8'(X_MAX);
    localparam logic [6:0]  Y_BASE     = 7'(Y_MIN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SPAWN = 2'd1,
        S_FLY   = 2'd2,
        S_DEAD  = 2'd3
    } state_t;

    state_t        state_r, state_nxt;
    logic [15:0]   lfsr_r, lfsr_nxt;
    logic [3:0]    frame_cnt_r, frame_cnt_nxt;
    logic [DW-1:0] delay_cnt_r, delay_cnt_nxt;
    logic [7:0]    x_nxt;
    logic [6:0]    y_nxt;
    logic          respawn_nxt, escaped_nxt;
    logic [4:0]    eff_freq_s, frame_inc_s;
    logic [6:0]    pick_s;

    function automatic logic [15:0] lfsr_advance(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_MASK : 16'h0000);
    endfunction

    // Next-state and next-output decode; enable outranks hit, hit outranks a step.
    always_comb begin
        lfsr_nxt      = lfsr_advance(lfsr_r);
        pick_s        = lfsr_r[6:0];
        eff_freq_s    = (move_freq == 4'd0) ? 5'd1 : {1'b0, move_freq};
        frame_inc_s   = {1'b0, frame_cnt_r} + 5'd1;
        state_nxt     = state_r;
        x_nxt         = x;
        y_nxt         = y;
        frame_cnt_nxt = frame_cnt_r;
        delay_cnt_nxt = delay_cnt_r;
        respawn_nxt   = 1'b0;
        escaped_nxt   = 1'b0;
        if (!enable) begin
            state_nxt = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    state_nxt = S_SPAWN;
                end
                S_SPAWN: begin
                    if (pick_s < 7'd100) begin
                        state_nxt     = S_FLY;
                        x_nxt         = 8'd0;
                        y_nxt         = Y_BASE + pick_s;
                        frame_cnt_nxt = 4'd0;
                        respawn_nxt   = 1'b1;
                    end else begin
                        state_nxt = S_SPAWN;
                    end
                end
                S_FLY: begin
                    if (hit) begin
                        state_nxt     = S_DEAD;
                        delay_cnt_nxt = DELAY_LOAD;
                    end else if (frame_tick) begin
                        if (frame_inc_s >= eff_freq_s) begin
                            frame_cnt_nxt = 4'd0;
                            if (x == X_LAST) begin
                                state_nxt   = S_SPAWN;
                                x_nxt       = 8'd0;
                                escaped_nxt = 1'b1;
                            end else begin
                                x_nxt = x + 8'd1;
                            end
                        end else begin
                            frame_cnt_nxt = frame_inc_s[3:0];
                        end
                    end else begin
                        frame_cnt_nxt = frame_cnt_r;
                    end
                end
                S_DEAD: begin
                    // A zero delay load also lands here on the first tick.
                    if (frame_tick) begin
                        if (delay_cnt_r <= DELAY_ONE) begin
                            state_nxt     = S_SPAWN;
                            delay_cnt_nxt = {DW{1'b0}};
                        end else begin
                            delay_cnt_nxt = delay_cnt_r - DELAY_ONE;
                        end
                    end else begin
                        delay_cnt_nxt = delay_cnt_r;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // State, counters, LFSR and all outputs are registered together.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= S_IDLE;
            lfsr_r      <= SEED_EFF;
            frame_cnt_r <= 4'd0;
            delay_cnt_r <= {DW{1'b0}};
            x           <= 8'd0;
            y           <= Y_BASE;
            active      <= 1'b0;
            respawn     <= 1'b0;
            escaped     <= 1'b0;
        end else begin
            state_r     <= state_nxt;
            lfsr_r      <= lfsr_nxt;
            frame_cnt_r <= frame_cnt_nxt;
            delay_cnt_r <= delay_cnt_nxt;
            x           <= x_nxt;
            y           <= y_nxt;
            active      <= (state_nxt == S_FLY);
            respawn     <= respawn_nxt;
            escaped     <= escaped_nxt;
        end
    end
endmodule

// File: tb/tb_bird_spawner.sv
// Self-checking bench for bird_spawner: directed scenarios plus a randomized
// run, all compared against a behavioural model of the bird's life cycle.
module tb_bird_spawner;
    localparam int X_MAX = 159;
    localparam int Y_MIN = 10;
    localparam int RESPAWN_DELAY = 30;
    localparam int P_IDLE = 0, P_SPAWN = 1, P_FLY = 2, P_DEAD = 3;

    logic       clock = 1'b0;
    logic       reset, frame_tick, enable, hit;
    logic [3:0] move_freq;
    logic [7:0] x;
    logic [6:0] y;
    logic       active, respawn, escaped;

    int checks = 0;
    int failures = 0;

    // behavioural model of the bird
    int          m_phase, m_x, m_y, m_frames, m_dead;
    int unsigned m_lfsr;
    bit          m_active, m_resp, m_esc;

    bird_spawner dut (
        .clock(clock), .reset(reset), .frame_tick(frame_tick), .enable(enable),
        .move_freq(move_freq), .hit(hit), .x(x), .y(y), .active(active),
        .respawn(respawn), .escaped(escaped)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        m_phase = P_IDLE; m_x = 0; m_y = Y_MIN; m_frames = 0; m_dead = 0;
        m_lfsr = 32'hACE1; m_active = 0; m_resp = 0; m_esc = 0;
    endtask

    task automatic model_step(input bit ft, input bit en, input int mf, input bit h);
        int eff;
        int roll;
        eff = (mf == 0) ? 1 : mf;
        roll = int'(m_lfsr % 128);
        m_resp = 0;
        m_esc = 0;
        if (!en) m_phase = P_IDLE;
        else if (m_phase == P_IDLE) m_phase = P_SPAWN;
        else if (m_phase == P_SPAWN) begin
            if (roll < 100) begin
                m_phase = P_FLY; m_x = 0; m_y = Y_MIN + roll; m_frames = 0; m_resp = 1;
            end
        end else if (m_phase == P_FLY) begin
            if (h) begin
                m_phase = P_DEAD; m_dead = RESPAWN_DELAY;
            end else if (ft) begin
                m_frames = m_frames + 1;
                if (m_frames >= eff) begin
                    m_frames = 0;
                    if (m_x == X_MAX) begin m_phase = P_SPAWN; m_x = 0; m_esc = 1; end
                    else m_x = m_x + 1;
                end
            end
        end else begin
            if (ft) begin
                if (m_dead <= 1) m_phase = P_SPAWN;
                else m_dead = m_dead - 1;
            end
        end
        m_lfsr = (m_lfsr >> 1) ^ (((m_lfsr & 1) != 0) ? 32'hB400 : 32'h0);
        m_active = (m_phase == P_FLY);
    endtask

    task automatic cycle(input bit ft, input bit en, input int mf, input bit h, input bit rst);
        frame_tick = ft; enable = en; move_freq = 4'(mf); hit = h; reset = rst;
        @(posedge clock);
        if (rst) model_reset();
        else model_step(ft, en, mf, h);
        #1;
    endtask

    task automatic test_reset();
        cycle(0, 0, 1, 0, 1);
        cycle(1, 1, 1, 1, 1);
        checks++; if (x !== 8'd0) begin failures++; $display("FAIL reset_x got=%0d exp=0", x); end
        checks++; if (y !== 7'd10) begin failures++; $display("FAIL reset_y got=%0d exp=10", y); end
        checks++; if ({active, respawn, escaped} !== 3'b000) begin failures++;
            $display("FAIL reset_flags got=%b exp=000", {active, respawn, escaped}); end
        checks++; if (dut.lfsr_r !== 16'hACE1) begin failures++;
            $display("FAIL reset_lfsr got=%h exp=ace1", dut.lfsr_r); end
    endtask

    task automatic wait_respawn(input string tag, input int mf);
        bit got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            cycle(0, 1, mf, 0, 0);
            got = respawn;
        end
        checks++; if (!got) begin failures++; $display("FAIL %s_respawn got=none exp=pulse<=20cyc", tag); end
        checks++; if (x !== 8'd0 || active !== 1'b1) begin failures++;
            $display("FAIL %s_spawnpos got x=%0d act=%b exp x=0 act=1", tag, x, active); end
        checks++; if (y !== 7'(m_y) || y < 7'd10 || y > 7'd109) begin failures++;
            $display("FAIL %s_spawny got=%0d exp=%0d", tag, y, m_y); end
    endtask

    task automatic test_spawn();
        cycle(0, 1, 1, 0, 0);
        wait_respawn("spawn", 1);
    endtask

    task automatic test_move();
        int x0;
        x0 = m_x;
        for (int i = 0; i < 9; i++) begin cycle(1, 1, 3, 0, 0); cycle(0, 1, 3, 0, 0); end
        checks++; if (x !== 8'(x0 + 3) || x !== 8'(m_x)) begin failures++;
            $display("FAIL move_freq3 got=%0d exp=%0d", x, x0 + 3); end
        for (int i = 0; i < 4; i++) begin cycle(1, 1, 0, 0, 0); cycle(0, 1, 0, 0, 0); end
        checks++; if (x !== 8'(x0 + 7)) begin failures++;
            $display("FAIL move_freq0 got=%0d exp=%0d", x, x0 + 7); end
    endtask

    task automatic test_escape();
        int need, ticks, esc_cnt;
        bit got;
        need = X_MAX + 1 - m_x;
        ticks = 0; esc_cnt = 0; got = 0;
        while (!got && ticks < 200) begin
            cycle(1, 1, 1, 0, 0);
            ticks++;
            got = escaped;
            if (escaped) esc_cnt++;
            cycle(0, 1, 1, 0, 0);
            if (escaped) esc_cnt++;
        end
        checks++; if (ticks !== need) begin failures++;
            $display("FAIL escape_ticks got=%0d exp=%0d", ticks, need); end
        checks++; if (x !== 8'd0) begin failures++; $display("FAIL escape_x got=%0d exp=0", x); end
        for (int i = 0; i < 20 && !respawn; i++) begin
            cycle(0, 1, 1, 0, 0);
            if (escaped) esc_cnt++;
            if (i == 0 && !respawn) begin
                checks++; if (active !== 1'b0) begin failures++;
                    $display("FAIL escape_spawn_active got=%b exp=0", active); end
            end
        end
        checks++; if (esc_cnt !== 1) begin failures++; $display("FAIL escape_count got=%0d exp=1", esc_cnt); end
        checks++; if (respawn !== 1'b1 || x !== 8'd0) begin failures++;
            $display("FAIL escape_respawn got resp=%b x=%0d exp resp=1 x=0", respawn, x); end
    endtask

    task automatic test_hit();
        int xh, resp_cnt;
        for (int i = 0; i < 3; i++) begin cycle(1, 1, 1, 0, 0); cycle(0, 1, 1, 0, 0); end
        xh = m_x;
        cycle(1, 1, 1, 1, 0);
        checks++; if (x !== 8'(xh) || active !== 1'b0) begin failures++;
            $display("FAIL hit_step got x=%0d act=%b exp x=%0d act=0", x, active, xh); end
        resp_cnt = 0;
        for (int i = 0; i < RESPAWN_DELAY - 1; i++) begin
            cycle(1, 1, 1, (i % 7) == 3, 0);
            if (respawn || active) resp_cnt++;
            cycle(0, 1, 1, 0, 0);
            if (respawn || active) resp_cnt++;
        end
        checks++; if (resp_cnt !== 0) begin failures++;
            $display("FAIL hit_early_respawn got=%0d exp=0", resp_cnt); end
        cycle(1, 1, 1, 0, 0);
        wait_respawn("hit", 1);
    endtask

    task automatic test_enable_drop();
        int bad;
        cycle(0, 1, 1, 1, 0);
        for (int i = 0; i < 5; i++) cycle(1, 1, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 1, 1, 0);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(i % 2, 0, 1, i % 3 == 0, 0);
            if (active || respawn || escaped) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL drop_quiet got=%0d exp=0", bad); end
        checks++; if (active !== 1'b0) begin failures++; $display("FAIL drop_active got=%b exp=0", active); end
        wait_respawn("reenable", 1);
    endtask

    task automatic test_reset_midfly();
        for (int i = 0; i < 80 && m_x != 57; i++) cycle(1, 1, 1, 0, 0);
        checks++; if (x !== 8'd57) begin failures++; $display("FAIL midfly_x got=%0d exp=57", x); end
        cycle(1, 1, 1, 1, 1);
        checks++; if (x !== 8'd0 || y !== 7'd10 || active !== 1'b0) begin failures++;
            $display("FAIL midfly_reset got x=%0d y=%0d act=%b exp x=0 y=10 act=0", x, y, active); end
        checks++; if (dut.lfsr_r !== 16'hACE1) begin failures++;
            $display("FAIL midfly_lfsr got=%h exp=ace1", dut.lfsr_r); end
    endtask

    task automatic test_random();
        int mf, nprint;
        bit ft, en, h, rst;
        mf = 2; nprint = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(99) < 5) mf = $urandom_range(15);
            ft  = $urandom_range(99) < 35;
            en  = $urandom_range(99) < 97;
            h   = $urandom_range(99) < 3;
            rst = $urandom_range(999) < 2;
            cycle(ft, en, mf, h, rst);
            checks++;
            if (x !== 8'(m_x) || y !== 7'(m_y) || active !== m_active ||
                respawn !== m_resp || escaped !== m_esc || (respawn && escaped)) begin
                failures++;
                if (nprint < 10) begin
                    nprint++;
                    $display("FAIL random_cyc%0d got x=%0d y=%0d a=%b r=%b e=%b exp x=%0d y=%0d a=%b r=%b e=%b",
                             i, x, y, active, respawn, escaped, m_x, m_y, m_active, m_resp, m_esc);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_spawn();
        test_move();
        test_escape();
        test_hit();
        test_enable_drop();
        test_reset_midfly();
        cycle(0, 1, 1, 0, 0);
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bird_spawner.md
BIRD_SPAWNER -- requirements
Module: bird_spawner

Interface
REQ-001 Parameter SEED, default 16'hACE1, initial LFSR value; a value of 0 SHALL be loaded as 16'h0001.
REQ-002 Parameter X_MAX, default 159, last on-screen x column.
REQ-003 Parameter Y_MIN, default 10, lowest spawn row; spawn rows SHALL be Y_MIN..Y_MIN+99.
REQ-004 Parameter RESPAWN_DELAY, default 30, frames spent dead after a hit.
REQ-005 clock  in  1  system clock, all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 frame_tick  in  1  one-cycle pulse per video frame.
REQ-008 enable  in  1  this bird slot is in play.
REQ-009 move_freq  in  4  frames per 1-pixel x step; 0 SHALL be treated as 1.
REQ-010 hit  in  1  one-cycle pulse: laser struck this bird.
REQ-011 x  out  8  bird head column, registered.
REQ-012 y  out  7  bird row, registered, constant while FLY.
REQ-013 active  out  1  high only in FLY; downstream draws the bird only when high.
REQ-014 respawn  out  1  one-cycle pulse on the first FLY cycle after each spawn.
REQ-015 escaped  out  1  one-cycle pulse when the bird leaves the right edge.

Function
REQ-016 States SHALL be IDLE, SPAWN, FLY, DEAD, held in a registered state variable.
REQ-017 16-bit Galois LFSR, mask 16'hB400, SHALL advance every clock cycle in every state except during reset.
REQ-018 IDLE: enable=1 -> SPAWN next cycle; otherwise stay.
REQ-019 SPAWN: if lfsr[6:0] < 100, accept: next cycle state=FLY, y=Y_MIN+lfsr[6:0], x=0, frame_cnt=0, respawn=1; else stay in SPAWN and retry next cycle.
REQ-020 FLY, frame_tick=1: if frame_cnt+1 >= eff_freq, then frame_cnt<=0 and x steps; otherwise frame_cnt<=frame_cnt+1. eff_freq = max(move_freq,1).
REQ-021 An x step at x==X_MAX SHALL go to SPAWN with x<=0 and escaped=1 for one cycle; otherwise x<=x+1.
REQ-022 FLY, hit=1 -> DEAD next cycle, delay_cnt<=RESPAWN_DELAY, x and y held; hit SHALL take priority over a step in the same cycle.
REQ-023 DEAD: each frame_tick decrements delay_cnt; frame_tick while delay_cnt==1 (or RESPAWN_DELAY==0 on the first tick) -> SPAWN.
REQ-024 hit outside FLY SHALL be ignored.
REQ-025 enable=0 in any state -> IDLE next cycle, active=0, with no respawn or escaped pulse; enable has priority over hit and frame_tick.
REQ-026 A move_freq change SHALL take effect at the next frame_tick compare; no step is lost or duplicated beyond the REQ-020 rule.
REQ-027 active SHALL be a registered decode of state==FLY; respawn and escaped SHALL never both be high.

Reset
REQ-028 On reset: state=IDLE, x=0, y=Y_MIN, active=0, respawn=0, escaped=0, frame_cnt=0, delay_cnt=0, lfsr=SEED (1 if SEED==0).
REQ-029 Reset SHALL override all inputs on the same edge, including mid-SPAWN, mid-FLY and mid-DEAD.

Verification
REQ-030 Reset, enable=1, SEED default -> respawn pulse within 20 cycles, x=0, 10<=y<=109, active=1.
REQ-031 FLY, move_freq=3, 9 frame_ticks -> x=3; move_freq=0, 4 ticks -> x advances by 4.
REQ-032 Force x=159 path (move_freq=1, 160 ticks from spawn) -> escaped pulse once, x=0, state passes through SPAWN, new respawn pulse.
REQ-033 hit on the same cycle as a stepping frame_tick -> x unchanged, active=0 next cycle; exactly 30 further ticks -> respawn pulse.
REQ-034 enable dropped mid-DEAD, then hit pulsed -> IDLE, active=0, no respawn/escaped; enable reasserted -> respawn within 20 cycles.
REQ-035 Reset asserted mid-FLY at x=57 -> next cycle x=0, y=10, active=0, lfsr=16'hACE1.
